// File: rtl/selftest_scheduler_if.sv
// BIST enable/result and ECC scrub port between the self-test scheduler (master)
// and the core/dmem ECC path (slave).
interface selftest_scheduler_if #(
    parameter int ADDR_W = 6
);
    logic              test_en_out;
    logic              test_done_in;
    logic [31:0]       signature_in;
    logic              scrub_req;
    logic [ADDR_W-1:0] scrub_addr;
    logic              scrub_ack;
    logic              s_err;
    logic              d_err;
    logic              scrub_wb;

    modport master (
        output test_en_out, scrub_req, scrub_addr, scrub_wb,
        input  test_done_in, signature_in, scrub_ack, s_err, d_err
    );

    modport slave (
        input  test_en_out, scrub_req, scrub_addr, scrub_wb,
        output test_done_in, signature_in, scrub_ack, s_err, d_err
    );
endinterface

// File: rtl/selftest_scheduler.sv
// Run-time self-test controller: ALU BIST signature check, then ECC scrub walk.
// Define SCHED_PERIODIC_EN to add the periodic run trigger.
module selftest_scheduler #(
    parameter logic [31:0] GOLDEN_SIG  = 32'h81c6f051,
    parameter int          ADDR_W      = 6,
    parameter int          SCRUB_WORDS = 64,
    parameter int          TIMEOUT     = 4096,
    parameter int          PERIOD      = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 periodic_en,
    input  logic                 loader_done_in,
    input  logic                 pipe_idle,
    selftest_scheduler_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 alu_fail,
    output logic [7:0]           sbe_count,
    output logic                 dbe_flag,
    output logic                 timeout_flag
);
    localparam int                CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SCRUB_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_IDLE, BIST, BIST_CHK, SCRUB_WAIT, SCRUB_WB, REPORT
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  phase_cnt;
    logic [ADDR_W-1:0] addr;
    logic              periodic_fire;
    logic              clr_status, cnt_clr, cnt_inc, addr_clr, addr_inc;
    logic              sig_chk, sbe_inc, dbe_set, to_set;
    logic              cnt_max, addr_last;

`ifdef SCHED_PERIODIC_EN
    logic [31:0] period_cnt;

    // Holds at the fire value if the loader is not done yet, so the run
    // starts as soon as loading completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               period_cnt <= '0;
        else if (state != IDLE || !periodic_en) period_cnt <= '0;
        else if (!periodic_fire)               period_cnt <= period_cnt + 32'd1;
    end

    assign periodic_fire = (state == IDLE) && periodic_en && (period_cnt == 32'(PERIOD - 1));
`else
    logic unused_periodic;
    assign unused_periodic = periodic_en ^ PERIOD[0];
    assign periodic_fire   = 1'b0;
`endif

    assign cnt_max   = (phase_cnt == CNT_MAX);
    assign addr_last = (addr == ADDR_LAST);

    always_comb begin
        state_nxt  = state;
        clr_status = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        addr_clr   = 1'b0;
        addr_inc   = 1'b0;
        sig_chk    = 1'b0;
        sbe_inc    = 1'b0;
        dbe_set    = 1'b0;
        to_set     = 1'b0;
        case (state)
            IDLE: begin
                if ((start | periodic_fire) & loader_done_in) state_nxt = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (pipe_idle) begin
                    state_nxt  = BIST;
                    clr_status = 1'b1;
                    cnt_clr    = 1'b1;
                end
            end
            BIST: begin
                if (bus.test_done_in) begin
                    state_nxt = BIST_CHK;
                end else if (cnt_max) begin
                    to_set    = 1'b1;
                    state_nxt = REPORT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            BIST_CHK: begin
                sig_chk   = 1'b1;
                addr_clr  = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = SCRUB_WAIT;
            end
            SCRUB_WAIT: begin
                // An ack on the last timeout cycle still counts as a good read.
                if (bus.scrub_ack) begin
                    cnt_clr = 1'b1;
                    if (bus.d_err)      dbe_set = 1'b1;
                    else if (bus.s_err) sbe_inc = 1'b1;
                    if (bus.s_err && !bus.d_err) state_nxt = SCRUB_WB;
                    else if (addr_last)          state_nxt = REPORT;
                    else                         addr_inc  = 1'b1;
                end else if (cnt_max) begin
                    to_set    = 1'b1;
                    state_nxt = REPORT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            SCRUB_WB: begin
                if (addr_last) begin
                    state_nxt = REPORT;
                end else begin
                    addr_inc  = 1'b1;
                    state_nxt = SCRUB_WAIT;
                end
            end
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            phase_cnt    <= '0;
            addr         <= '0;
            alu_fail     <= 1'b0;
            sbe_count    <= '0;
            dbe_flag     <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cnt_clr)      phase_cnt <= '0;
            else if (cnt_inc) phase_cnt <= phase_cnt + CNT_W'(1);
            if (addr_clr)      addr <= '0;
            else if (addr_inc) addr <= addr + ADDR_W'(1);
            if (clr_status) begin
                alu_fail     <= 1'b0;
                sbe_count    <= '0;
                dbe_flag     <= 1'b0;
                timeout_flag <= 1'b0;
            end else begin
                if (sig_chk) alu_fail <= (bus.signature_in != GOLDEN_SIG);
                if (sbe_inc && sbe_count != 8'hff) sbe_count <= sbe_count + 8'd1;
                if (dbe_set) dbe_flag <= 1'b1;
                if (to_set)  timeout_flag <= 1'b1;
            end
        end
    end

    // All handshake outputs are decodes of the state register.
    assign busy            = (state != IDLE);
    assign done            = (state == REPORT);
    assign bus.test_en_out = (state == BIST);
    assign bus.scrub_req   = (state == SCRUB_WAIT);
    assign bus.scrub_wb    = (state == SCRUB_WB);
    assign bus.scrub_addr  = addr;
endmodule

// File: tb/tb_selftest_scheduler.sv
// Directed bench for selftest_scheduler: main instance (TIMEOUT 256) plus a
// short-timeout instance (TIMEOUT 16) for the timeout paths.
module tb_selftest_scheduler;
    localparam logic [31:0] GOLD = 32'h81c6f051;
    localparam logic [31:0] BAD  = 32'h81c6f151;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, periodic_en = 1'b0;
    logic       loader_done_in = 1'b0, pipe_idle = 1'b1, start2 = 1'b0;
    logic       busy, done, alu_fail, dbe_flag, timeout_flag;
    logic [7:0] sbe_count;
    logic       busy2, done2, alu_fail2, dbe_flag2, timeout_flag2;
    logic [7:0] sbe_count2;

    selftest_scheduler_if #(.ADDR_W(6)) bus1();
    selftest_scheduler_if #(.ADDR_W(6)) bus2();

    selftest_scheduler #(.GOLDEN_SIG(GOLD), .ADDR_W(6), .SCRUB_WORDS(4), .TIMEOUT(256), .PERIOD(100)) dut (
        .clk(clk), .rst(rst), .start(start), .periodic_en(periodic_en),
        .loader_done_in(loader_done_in), .pipe_idle(pipe_idle), .bus(bus1),
        .busy(busy), .done(done), .alu_fail(alu_fail), .sbe_count(sbe_count),
        .dbe_flag(dbe_flag), .timeout_flag(timeout_flag)
    );

    selftest_scheduler #(.GOLDEN_SIG(GOLD), .ADDR_W(6), .SCRUB_WORDS(4), .TIMEOUT(16), .PERIOD(100)) dut_to (
        .clk(clk), .rst(rst), .start(start2), .periodic_en(1'b0),
        .loader_done_in(1'b1), .pipe_idle(1'b1), .bus(bus2),
        .busy(busy2), .done(done2), .alu_fail(alu_fail2), .sbe_count(sbe_count2),
        .dbe_flag(dbe_flag2), .timeout_flag(timeout_flag2)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    // main-instance models and monitors (all updated on negedge)
    int bist_lat = 200, ack_lat = 1, serr_addr = -1, derr_addr = -1;
    int bist_cnt = 0, wcnt = 0, en_hi = 0, ack_cnt = 0, exp_addr = 0, seq_err = 0;
    int wb_cnt = 0, wb_addr = -1, wb_overlap = 0, done_cnt = 0;
    logic       prev_req = 1'b0;
    logic [5:0] prev_addr = '0;
    // short-timeout instance
    logic bist_hang2 = 1'b0;
    int   en2_hi = 0, req2_hi = 0, done2_cnt = 0;

    always @(negedge clk) begin
        if (bus1.test_en_out) begin
            bist_cnt++;
            en_hi++;
        end else begin
            bist_cnt = 0;
        end
        bus1.test_done_in = bus1.test_en_out && (bist_cnt >= bist_lat);
        if (bus1.scrub_req && prev_req && bus1.scrub_addr == prev_addr) wcnt++;
        else wcnt = 0;
        prev_req  = bus1.scrub_req;
        prev_addr = bus1.scrub_addr;
        bus1.scrub_ack = bus1.scrub_req && (wcnt == ack_lat);
        bus1.s_err     = bus1.scrub_ack && (int'(bus1.scrub_addr) == serr_addr);
        bus1.d_err     = bus1.scrub_ack && (int'(bus1.scrub_addr) == derr_addr);
        if (bus1.scrub_ack) begin
            if (int'(bus1.scrub_addr) != exp_addr) seq_err++;
            exp_addr++;
            ack_cnt++;
        end
        if (bus1.scrub_wb) begin
            wb_cnt++;
            wb_addr = int'(bus1.scrub_addr);
            if (bus1.scrub_req) wb_overlap++;
        end
        if (done) done_cnt++;
    end

    always @(negedge clk) begin
        bus2.test_done_in = bus2.test_en_out && !bist_hang2;
        bus2.scrub_ack    = 1'b0;
        bus2.s_err        = 1'b0;
        bus2.d_err        = 1'b0;
        if (bus2.test_en_out) en2_hi++;
        if (bus2.scrub_req)   req2_hi++;
        if (done2)            done2_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clr_mon();
        en_hi = 0; ack_cnt = 0; exp_addr = 0; seq_err = 0;
        wb_cnt = 0; wb_addr = -1; wb_overlap = 0;
    endtask

    task automatic wait_done(input string tag);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, 32'(done_cnt - base), 32'd1);
    endtask

    task automatic run2(input string tag);
        int base = done2_cnt;
        int n = 0;
        en2_hi = 0; req2_hi = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        while (done2_cnt == base && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(done2_cnt - base), 32'd1);
    endtask

    initial begin
        int base, n, first;
        logic any_busy;
        bus1.signature_in = GOLD;
        bus2.signature_in = GOLD;

        // reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_test_en", bus1.test_en_out, 0);
        chk("rst_req", bus1.scrub_req, 0);
        chk("rst_addr", bus1.scrub_addr, 0);
        chk("rst_wb", bus1.scrub_wb, 0);
        chk("rst_status", {alu_fail, dbe_flag, timeout_flag, sbe_count}, 0);
        rst = 1'b0;
        tick();

        // loader gating
        pulse_start();
        tick(); tick();
        chk("no_run_loader_low", busy, 0);
        loader_done_in = 1'b1;

        // fault-free run, second start during BIST ignored
        clr_mon();
        base = done_cnt;
        pulse_start();
        chk("busy_after_start", busy, 1);
        repeat (50) tick();
        pulse_start();
        wait_done("ok_done");
        repeat (10) tick();
        chk("ok_one_run", 32'(done_cnt - base), 32'd1);
        chk("ok_idle", busy, 0);
        chk("ok_en_cycles", 32'(en_hi), 32'd200);
        chk("ok_acks", 32'(ack_cnt), 32'd4);
        chk("ok_addr_seq", 32'(seq_err), 32'd0);
        chk("ok_alu_fail", alu_fail, 0);
        chk("ok_sbe", sbe_count, 0);
        chk("ok_dbe_to", {dbe_flag, timeout_flag}, 0);
        chk("ok_no_wb", 32'(wb_cnt), 32'd0);

        // faulty ALU signature: scrub still walks
        clr_mon();
        bus1.signature_in = BAD;
        pulse_start();
        wait_done("alu_done");
        chk("alu_fail_set", alu_fail, 1);
        chk("alu_acks", 32'(ack_cnt), 32'd4);
        bus1.signature_in = GOLD;

        // ECC: s_err at 1 (write-back), d_err at 3 (no write-back)
        clr_mon();
        serr_addr = 1; derr_addr = 3;
        pulse_start();
        wait_done("ecc_done");
        chk("ecc_alu_cleared", alu_fail, 0);
        chk("ecc_wb_cnt", 32'(wb_cnt), 32'd1);
        chk("ecc_wb_addr", 32'(wb_addr), 32'd1);
        chk("ecc_wb_no_req", 32'(wb_overlap), 32'd0);
        chk("ecc_sbe", sbe_count, 8'd1);
        chk("ecc_dbe", dbe_flag, 1);
        chk("ecc_acks", 32'(ack_cnt), 32'd4);
        chk("ecc_addr_seq", 32'(seq_err), 32'd0);
        repeat (20) tick();
        chk("ecc_sbe_hold", sbe_count, 8'd1);
        serr_addr = -1; derr_addr = -1;

        // pipe_idle gating; status cleared on BIST entry
        clr_mon();
        pipe_idle = 1'b0;
        pulse_start();
        repeat (30) tick();
        chk("pidle_busy", busy, 1);
        chk("pidle_no_en", bus1.test_en_out, 0);
        chk("pidle_sbe_held", sbe_count, 8'd1);
        pipe_idle = 1'b1;
        tick();
        chk("pidle_en_rise", bus1.test_en_out, 1);
        chk("bist_entry_clear", {dbe_flag, sbe_count}, 0);
        wait_done("pidle_done");

        // async reset mid-scrub at addr 2
        clr_mon();
        bist_lat = 20; ack_lat = 5; serr_addr = 0;
        pulse_start();
        n = 0;
        while (!(bus1.scrub_req && bus1.scrub_addr == 6'd2) && n < 600) begin
            tick();
            n++;
        end
        chk("mid_reach_addr2", n < 600, 1);
        chk("mid_sbe_pre", sbe_count, 8'd1);
        base = done_cnt;
        rst = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_req", bus1.scrub_req, 0);
        chk("mid_addr", bus1.scrub_addr, 0);
        chk("mid_sbe", sbe_count, 0);
        tick(); tick(); tick();
        chk("mid_no_done", 32'(done_cnt - base), 32'd0);
        rst = 1'b0;
        serr_addr = -1;
        tick();

        // periodic trigger
        periodic_en = 1'b1;
`ifdef SCHED_PERIODIC_EN
        first = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (busy) begin
                first = i;
                break;
            end
        end
        chk("periodic_start", 32'(first), 32'd100);
        periodic_en = 1'b0;
        wait_done("periodic_done");
`else
        any_busy = 1'b0;
        repeat (150) begin
            tick();
            if (busy) any_busy = 1'b1;
        end
        chk("no_periodic", any_busy, 0);
        periodic_en = 1'b0;
`endif

        // short-timeout instance: scrub never acked
        run2("to_scrub_done");
        chk("to_scrub_req_cycles", 32'(req2_hi), 32'd16);
        chk("to_scrub_flag", timeout_flag2, 1);
        chk("to_scrub_addr", bus2.scrub_addr, 0);
        chk("to_scrub_alu", alu_fail2, 0);

        // short-timeout instance: BIST never finishes, scrub skipped
        bist_hang2 = 1'b1;
        run2("to_bist_done");
        chk("to_bist_en_cycles", 32'(en2_hi), 32'd16);
        chk("to_bist_no_scrub", 32'(req2_hi), 32'd0);
        chk("to_bist_flag", timeout_flag2, 1);
        chk("to_bist_en_low", bus2.test_en_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
